// File: rtl/i2c_cmd_arbiter_pkg.sv
// i2c_arb_pkg: shared types and constants for the I2C command arbiter.
//   arb_state_e : arbiter FSM states (IDLE, LAUNCH, WAIT, DONE)
//   ADDR_W      : I2C slave address width (7)
//   DATA_W      : I2C data byte width (8)
package i2c_arb_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE
  } arb_state_e;

endpackage

// File: rtl/i2c_cmd_arbiter_if.sv
// i2c_cmd_arbiter_if: requester-side and I2C-master-side signals of the arbiter.
//   Requester side : req_valid/req_addr/req_rw/req_wdata in, req_ready/rsp_* /grant out
//   Master side    : m_addr/m_rw/m_wdata/m_enable out, m_ready/m_rdata/m_tx_rd_en/m_rx_wr_en in
//   modport slave  : the arbiter's view
//   modport master : the environment's view (requesters + I2C master)
interface i2c_cmd_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import i2c_arb_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [ADDR_W*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_rw;
  logic [DATA_W*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic [NUM_REQ-1:0]        grant;

  logic [ADDR_W-1:0]         m_addr;
  logic                      m_rw;
  logic [DATA_W-1:0]         m_wdata;
  logic                      m_enable;
  logic                      m_ready;
  logic [DATA_W-1:0]         m_rdata;
  logic                      m_tx_rd_en;
  logic                      m_rx_wr_en;

  modport slave (
    input  req_valid, req_addr, req_rw, req_wdata,
    input  m_ready, m_rdata, m_tx_rd_en, m_rx_wr_en,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, grant,
    output m_addr, m_rw, m_wdata, m_enable
  );

  modport master (
    output req_valid, req_addr, req_rw, req_wdata,
    output m_ready, m_rdata, m_tx_rd_en, m_rx_wr_en,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, grant,
    input  m_addr, m_rw, m_wdata, m_enable
  );

endinterface

// File: rtl/i2c_cmd_arbiter_rr_arbiter.sv
// i2c_rr_arbiter: combinational round-robin pick.
//   req_i : pending request vector
//   ptr_i : index with highest priority this round
//   gnt_o : one-hot winner (all zero when no request)
module i2c_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_i) + i) % NUM_REQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin arbiter sharing one I2C master among NUM_REQ requesters.
//   clk          : system clock, posedge
//   i2c_reset_n  : asynchronous active-low reset
//   bus          : i2c_cmd_arbiter_if.slave (requester handshake + master command/status)
// Optional: define I2C_ARB_TIMEOUT_EN to build a per-transaction abort counter
// (TIMEOUT_CYCLES); without it the WAIT state only exits on m_ready=1.
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic               clk,
  input logic               i2c_reset_n,
  i2c_cmd_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  arb_state_e          state_q;
  logic [PTR_W-1:0]    ptr_q, win_q, win_idx;
  logic [NUM_REQ-1:0]  win_oh, grant_q, req_ready_q, rsp_valid_q;
  logic [DATA_W-1:0]   rdata_q, m_wdata_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic                m_rw_q, m_enable_q, rsp_err_q, seen_ok_q, seen_ok_d;
  logic                in_xfer, timeout_hit;

  i2c_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (win_oh)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (win_oh[i]) win_idx = PTR_W'(i);
  end

  assign in_xfer   = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
  // Includes this cycle's strobe so an ACK coinciding with m_ready rising still counts.
  assign seen_ok_d = seen_ok_q |
                     (in_xfer && ((bus.m_tx_rd_en && !m_rw_q) || (bus.m_rx_wr_en && m_rw_q)));

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge i2c_reset_n) begin
    if (!i2c_reset_n)  to_cnt_q <= '0;
    else if (in_xfer)  to_cnt_q <= to_cnt_q + 1'b1;
    else               to_cnt_q <= '0;
  end

  assign timeout_hit = in_xfer && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
  // TIMEOUT_CYCLES only matters when the counter is built.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or negedge i2c_reset_n) begin
    if (!i2c_reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      grant_q     <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
      m_enable_q  <= 1'b0;
      m_addr_q    <= '0;
      m_rw_q      <= 1'b0;
      m_wdata_q   <= '0;
      seen_ok_q   <= 1'b0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      if (in_xfer) begin
        seen_ok_q <= seen_ok_d;
        if (bus.m_rx_wr_en) rdata_q <= bus.m_rdata;
      end
      case (state_q)
        ST_IDLE: begin
          if ((|bus.req_valid) && bus.m_ready) begin
            m_addr_q    <= bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            m_rw_q      <= bus.req_rw[win_idx];
            m_wdata_q   <= bus.req_wdata[int'(win_idx)*DATA_W +: DATA_W];
            req_ready_q <= win_oh;
            grant_q     <= win_oh;
            win_q       <= win_idx;
            m_enable_q  <= 1'b1;
            state_q     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH, ST_WAIT: begin
          // Response is registered on the way into DONE so the pulse coincides with DONE.
          if (timeout_hit) begin
            rsp_valid_q <= grant_q;
            rsp_err_q   <= 1'b1;
            m_enable_q  <= 1'b0;
            state_q     <= ST_DONE;
          end else if (state_q == ST_LAUNCH) begin
            if (!bus.m_ready) begin
              m_enable_q <= 1'b0;
              state_q    <= ST_WAIT;
            end
          end else if (bus.m_ready) begin
            rsp_valid_q <= grant_q;
            rsp_err_q   <= !seen_ok_d;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          ptr_q     <= (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
          grant_q   <= '0;
          seen_ok_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.grant     = grant_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_rw      = m_rw_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_enable  = m_enable_q;

endmodule
